ik_angle_sequencer: RTL and testbench
=====================================

Name: ik_angle_sequencer

Overview:
- Parametrised next-generation inverse-kinematics sequencer for the two-link SCARA arm.
- Accepts targets through a small queue and converts each coordinate by mode. Drives level-enable handshakes to an external stage engine (conversion / cos / sin / k1 / k2) and to one shared atan2 unit, then forms th1/th2.
- Adds over the current angle calculator: target queueing, output backpressure, per-stage timeout with abort, and elbow-up/down selection.

Parameters:
- COORD_W, 14, target coordinate width; converted width is COORD_W+1.
- ANGLE_W, 13, signed angle width.
- FIFO_DEPTH, 4, target queue depth; power of 2, ≥2.
- TIMEOUT, 1023, max cycles in any wait state before abort.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  target offered
- in_ready  out  1  queue not full
- in_x, in_y  in  COORD_W each  target coordinates
- in_relative  in  1  1 = sign-magnitude coordinates, 0 = unsigned absolute
- in_elbow  in  1  0 = elbow-down, 1 = elbow-up
- conv_x, conv_y  out  COORD_W+1 each  converted coordinates (two's complement), held per job
- stage_en  out  1  stage engine enable (level)
- stage_id  out  3  0 conv, 1 cos, 2 sin, 3 k1, 4 k2
- stage_done  in  1  stage engine finished
- atan_en  out  1  atan2 enable (level)
- atan_sel  out  2  0 gamma (k2,k1), 1 xy (y,x), 2 th2 (sin,cos)
- atan_done  in  1  atan2 result valid
- atan_angle  in  ANGLE_W signed  atan2 result
- out_valid  out  1  th1/th2 valid
- out_ready  in  1  consumer accepts
- th1, th2  out  ANGLE_W signed  joint angles
- busy  out  1  state ≠ IDLE
- err_pulse  out  1  one-cycle timeout strobe
- err_code  out  4  {1'b1 atan / 1'b0 stage, id/sel} of last timeout
- fifo_count  out  clog2(FIFO_DEPTH)+1  queue occupancy

Behaviour:
- Reset (async, low) clears: queue empty, state IDLE, all outputs 0, in_ready 1.
- Queue:
  - push when in_valid & in_ready; stored fields are {x, y, relative, elbow}.
  - pop only in LOAD; push and pop in the same cycle leave the count unchanged.
  - in_ready = !full; an offer while full is not accepted.
- Conversion, latched in LOAD:
  - relative=1: MSB is the sign, remainder is the magnitude → two's complement COORD_W+1 (negative zero → 0).
  - relative=0: zero-extend.
- States: IDLE → LOAD → CONV → COS → SIN → K1 → K2 → GAMMA → ATANXY → TH2 → CALC → OUT → IDLE.
- IDLE → LOAD when fifo_count ≠ 0. LOAD lasts one cycle.
- Wait states CONV..K2: stage_en=1 and stage_id decoded from the registered state. The state advances on the edge where stage_done=1. Enables are Moore outputs, so they drop the cycle after done.
- Wait states GAMMA..TH2: atan_en=1 and atan_sel decoded from state. On atan_done, latch atan_angle into gamma, axy or t2, then advance.
- A done input is ignored unless its enable is currently asserted; stage_done in an atan state and atan_done in a stage state are ignored.
- CALC, one cycle:
  - elbow=0: th1 = axy − gamma, th2 = t2.
  - elbow=1: th1 = axy + gamma, th2 = −t2.
  - All arithmetic is modulo 2^ANGLE_W (wraps, no saturation).
- OUT: out_valid=1; th1/th2 are stable until out_ready=1 at an edge, then → IDLE. From OUT, the next job's LOAD starts no earlier than the cycle after the handshake.
- Timeout:
  - the cycle counter clears on entry to each wait state.
  - reaching TIMEOUT without done: err_pulse=1 for one cycle, err_code updated, job discarded (no out_valid), → IDLE.
  - th1/th2 keep their previous values; err_code holds until the next timeout.
- Minimum latency (engines assert done in the first enabled cycle, queue empty, IDLE): push at edge k → out_valid high after edge k+11.
- A reset asserted mid-job aborts immediately; the queue is flushed and no output is produced.

Test Plan:
- Absolute, elbow=0, x=0x0100, y=0x0200; engines done first cycle; atan_angle gamma=100, xy=500, th2=300 → conv_x=0x00100; out_valid at k+11; th1=400, th2=300.
- Relative, in_x=0x2005 (−5), in_y=0x0005, elbow=1; gamma=−50, xy=4000, th2=200 → conv_x=−5, conv_y=+5; th1=3950, th2=−200; additionally axy=4095, gamma=1 with elbow=1 → th1 wraps to −4096.
- Backpressure: out_ready=0 for 20 cycles while pushing 5 targets with FIFO_DEPTH=4 → in_ready low once 4 are queued (one job in flight); th1/th2 stable; all jobs emerge in order.
- Timeout: TIMEOUT=8, stage_done never asserted in SIN → err_pulse once, 8 cycles after SIN entry; err_code=4'b0010; no out_valid; next queued job completes normally.
- Spurious done: atan_done pulsed during COS, stage_done pulsed during GAMMA → both ignored; sequence and results are unchanged.
- Reset mid-job (in ATANXY, 2 queued) → all outputs 0, fifo_count=0, busy=0 the same cycle; no output after release.

Source files
------------

// File: rtl/ik_angle_sequencer_if.sv
// Bundle of target stream, stage/atan engine handshakes, result stream and status of the IK sequencer.
// The master modport is the sequencer itself and the slave modport is everything around it.
interface ik_angle_sequencer_if #(
  parameter int COORD_W    = 14,
  parameter int ANGLE_W    = 13,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [COORD_W-1:0]        in_x;
  logic [COORD_W-1:0]        in_y;
  logic                      in_relative;
  logic                      in_elbow;
  logic [COORD_W:0]          conv_x;
  logic [COORD_W:0]          conv_y;
  logic                      stage_en;
  logic [2:0]                stage_id;
  logic                      stage_done;
  logic                      atan_en;
  logic [1:0]                atan_sel;
  logic                      atan_done;
  logic signed [ANGLE_W-1:0] atan_angle;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [ANGLE_W-1:0] th1;
  logic signed [ANGLE_W-1:0] th2;
  logic                      busy;
  logic                      err_pulse;
  logic [3:0]                err_code;
  logic [CNT_W-1:0]          fifo_count;

  modport master (
    input  in_valid, in_x, in_y, in_relative, in_elbow,
    input  stage_done, atan_done, atan_angle, out_ready,
    output in_ready, conv_x, conv_y, stage_en, stage_id, atan_en, atan_sel,
    output out_valid, th1, th2, busy, err_pulse, err_code, fifo_count
  );

  modport slave (
    output in_valid, in_x, in_y, in_relative, in_elbow,
    output stage_done, atan_done, atan_angle, out_ready,
    input  in_ready, conv_x, conv_y, stage_en, stage_id, atan_en, atan_sel,
    input  out_valid, th1, th2, busy, err_pulse, err_code, fifo_count
  );
endinterface

// File: rtl/ik_angle_sequencer.sv
// Two-link SCARA inverse-kinematics sequencer: queues targets, steps the external stage and
// atan2 engines through one job at a time, and presents th1/th2 with backpressure and timeout abort.
module ik_angle_sequencer #(
  parameter int COORD_W    = 14,
  parameter int ANGLE_W    = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input logic clk,
  input logic reset,
  ik_angle_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CONV, S_COS, S_SIN, S_K1, S_K2,
    S_GAMMA, S_ATANXY, S_TH2, S_CALC, S_OUT
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               relative;
    logic               elbow;
  } job_t;

  state_t state, state_next, adv_state;

  job_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, push, pop;
  job_t             head;

  logic [TMR_W-1:0] timer;
  logic             stage_en, atan_en, out_valid, done_now, timed_out;
  logic [2:0]       stage_id;
  logic [1:0]       atan_sel;

  logic [COORD_W:0]          conv_x, conv_y;
  logic                      job_elbow;
  logic signed [ANGLE_W-1:0] gamma, axy, t2, th1, th2;
  logic                      err_pulse;
  logic [3:0]                err_code;

  function automatic logic [COORD_W:0] to_twos(input logic [COORD_W-1:0] v, input logic rel);
    logic [COORD_W:0] mag;
    mag = {2'b00, v[COORD_W-2:0]};
    if (!rel)
      return {1'b0, v};
    return v[COORD_W-1] ? -mag : mag;
  endfunction

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign push = bus.in_valid & ~full;
  assign pop  = (state == S_LOAD);
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.in_x, bus.in_y, bus.in_relative, bus.in_elbow};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    adv_state  = state;
    stage_en   = 1'b0;
    stage_id   = 3'd0;
    atan_en    = 1'b0;
    atan_sel   = 2'd0;
    out_valid  = 1'b0;
    done_now   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE:   if (count != '0) state_next = S_LOAD;
      S_LOAD:   state_next = S_CONV;
      S_CONV:   begin stage_en = 1'b1; stage_id = 3'd0; adv_state = S_COS;    end
      S_COS:    begin stage_en = 1'b1; stage_id = 3'd1; adv_state = S_SIN;    end
      S_SIN:    begin stage_en = 1'b1; stage_id = 3'd2; adv_state = S_K1;     end
      S_K1:     begin stage_en = 1'b1; stage_id = 3'd3; adv_state = S_K2;     end
      S_K2:     begin stage_en = 1'b1; stage_id = 3'd4; adv_state = S_GAMMA;  end
      S_GAMMA:  begin atan_en  = 1'b1; atan_sel = 2'd0; adv_state = S_ATANXY; end
      S_ATANXY: begin atan_en  = 1'b1; atan_sel = 2'd1; adv_state = S_TH2;    end
      S_TH2:    begin atan_en  = 1'b1; atan_sel = 2'd2; adv_state = S_CALC;   end
      S_CALC:   state_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
    // A done strobe only counts when its own enable is currently raised.
    done_now = (stage_en & bus.stage_done) | (atan_en & bus.atan_done);
    if (stage_en | atan_en) begin
      if (done_now) begin
        state_next = adv_state;
      end else if (timer == TMO_LAST) begin
        state_next = S_IDLE;
        timed_out  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timer <= '0;
    else if ((state_next != state) || !(stage_en | atan_en))
      timer <= '0;
    else
      timer <= timer + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_x    <= '0;
      conv_y    <= '0;
      job_elbow <= 1'b0;
      gamma     <= '0;
      axy       <= '0;
      t2        <= '0;
      th1       <= '0;
      th2       <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
    end else begin
      err_pulse <= timed_out;
      if (timed_out)
        err_code <= stage_en ? {1'b0, stage_id} : {2'b10, atan_sel};
      if (state == S_LOAD) begin
        conv_x    <= to_twos(head.x, head.relative);
        conv_y    <= to_twos(head.y, head.relative);
        job_elbow <= head.elbow;
      end
      if (atan_en & bus.atan_done) begin
        case (atan_sel)
          2'd0:    gamma <= bus.atan_angle;
          2'd1:    axy   <= bus.atan_angle;
          default: t2    <= bus.atan_angle;
        endcase
      end
      if (state == S_CALC) begin
        th1 <= job_elbow ? (axy + gamma) : (axy - gamma);
        th2 <= job_elbow ? -t2 : t2;
      end
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.conv_x     = conv_x;
  assign bus.conv_y     = conv_y;
  assign bus.stage_en   = stage_en;
  assign bus.stage_id   = stage_id;
  assign bus.atan_en    = atan_en;
  assign bus.atan_sel   = atan_sel;
  assign bus.out_valid  = out_valid;
  assign bus.th1        = th1;
  assign bus.th2        = th2;
  assign bus.busy       = (state != S_IDLE);
  assign bus.err_pulse  = err_pulse;
  assign bus.err_code   = err_code;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_ik_angle_sequencer.sv
// Randomised bench for ik_angle_sequencer: engine responders plus a job-level reference model
// (coordinate conversion and angle combination computed arithmetically per accepted target).
`timescale 1ns/1ps
module tb_ik_angle_sequencer;
  localparam int COORD_W    = 14;
  localparam int ANGLE_W    = 13;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 8;

  typedef struct {
    int cx;
    int cy;
    int th1;
    int th2;
  } want_t;

  logic clk = 1'b0;
  logic reset;

  ik_angle_sequencer_if #(.COORD_W(COORD_W), .ANGLE_W(ANGLE_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  ik_angle_sequencer #(
    .COORD_W(COORD_W), .ANGLE_W(ANGLE_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  want_t want_q[$];
  int    last_th1 = 0, last_th2 = 0;

  bit fast = 1, spur = 0, hang_en = 0, force_ang = 0;
  int hang_id = 0, rdy_mode = 1;
  int g_val = 0, xy_val = 0, t2_val = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int wrap_a(input int v);
    int m = 1 << ANGLE_W;
    v = v % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  function automatic int conv_ref(input int v, input bit rel);
    int half = 1 << (COORD_W - 1);
    if (!rel) return v;
    return (v >= half) ? -(v % half) : v;
  endfunction

  // Angle an engine reports for a given job; shared by the responder and the model.
  function automatic int stim_angle(input int sel, input int cx, input int cy);
    if (force_ang) return (sel == 0) ? g_val : (sel == 1) ? xy_val : t2_val;
    case (sel)
      0:       return wrap_a(3 * cx + cy);
      1:       return wrap_a(cx - 2 * cy + 77);
      default: return wrap_a(5 * cy - cx);
    endcase
  endfunction

  // Engine responder
  initial begin
    bit s_new = 1, a_new = 1;
    int s_wait = 0, a_wait = 0;
    bus.stage_done = 1'b0;
    bus.atan_done  = 1'b0;
    bus.atan_angle = '0;
    forever begin
      @(negedge clk);
      bus.stage_done = 1'b0;
      bus.atan_done  = 1'b0;
      bus.atan_angle = '0;
      if (!reset) begin
        s_new = 1;
        a_new = 1;
      end else begin
        if (bus.stage_en) begin
          if (s_new) begin s_wait = fast ? 0 : int'($urandom_range(0, 4)); s_new = 0; end
          if (!(hang_en && bus.stage_id == 3'(hang_id))) begin
            if (s_wait == 0) begin bus.stage_done = 1'b1; s_new = 1; end
            else s_wait--;
          end
          if (spur && $urandom_range(0, 2) == 0) begin
            bus.atan_done  = 1'b1;
            bus.atan_angle = ANGLE_W'($urandom);
          end
        end else s_new = 1;
        if (bus.atan_en) begin
          if (a_new) begin a_wait = fast ? 0 : int'($urandom_range(0, 4)); a_new = 0; end
          if (a_wait == 0) begin
            bus.atan_done  = 1'b1;
            bus.atan_angle = ANGLE_W'(stim_angle(int'(bus.atan_sel),
                                                 int'($signed(bus.conv_x)), int'($signed(bus.conv_y))));
            a_new = 1;
          end else begin
            a_wait--;
            if (spur) bus.atan_angle = ANGLE_W'($urandom);
          end
          if (spur && $urandom_range(0, 2) == 0) bus.stage_done = 1'b1;
        end else a_new = 1;
      end
    end
  end

  // Output monitor and consumer
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid) begin
        if (want_q.size() == 0) check_eq("spurious_valid", int'(bus.out_valid), 0);
        else begin
          check_eq("th1",    int'(bus.th1), want_q[0].th1);
          check_eq("th2",    int'(bus.th2), want_q[0].th2);
          check_eq("conv_x", int'($signed(bus.conv_x)), want_q[0].cx);
          check_eq("conv_y", int'($signed(bus.conv_y)), want_q[0].cy);
        end
      end
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset && bus.out_valid && bus.out_ready && want_q.size() != 0) begin
        last_th1 = want_q[0].th1;
        last_th2 = want_q[0].th2;
        void'(want_q.pop_front());
      end
    end
  end

  task automatic push_job(input int x, input int y, input bit rel, input bit elb, input bit keep);
    int    waitc = 0;
    want_t w;
    int    g, axy, t2;
    @(negedge clk);
    bus.in_x        = COORD_W'(x);
    bus.in_y        = COORD_W'(y);
    bus.in_relative = rel;
    bus.in_elbow    = elb;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) begin
      check_eq("push_timeout", int'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (keep) begin
      w.cx  = conv_ref(x, rel);
      w.cy  = conv_ref(y, rel);
      g     = stim_angle(0, w.cx, w.cy);
      axy   = stim_angle(1, w.cx, w.cy);
      t2    = stim_angle(2, w.cx, w.cy);
      w.th1 = elb ? wrap_a(axy + g) : wrap_a(axy - g);
      w.th2 = elb ? wrap_a(-t2) : wrap_a(t2);
      want_q.push_back(w);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((want_q.size() != 0 || bus.busy || bus.fifo_count != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_eq("drain_timeout", want_q.size(), 0);
  endtask

  task automatic run_directed(input int x, input int y, input bit rel, input bit elb,
                              input int g, input int xy, input int t,
                              input int cx, input int cy, input int r1, input int r2);
    int lat = 0;
    force_ang = 1;
    g_val = g; xy_val = xy; t2_val = t;
    push_job(x, y, rel, elb, 1);
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!bus.out_valid && lat < 40);
    check_eq("latency",  lat, 11);
    check_eq("d_conv_x", int'($signed(bus.conv_x)), cx);
    check_eq("d_conv_y", int'($signed(bus.conv_y)), cy);
    check_eq("d_th1",    int'(bus.th1), r1);
    check_eq("d_th2",    int'(bus.th2), r2);
    wait_drain();
    force_ang = 0;
  endtask

  task automatic push_random(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      push_job(int'($urandom_range(0, (1 << COORD_W) - 1)), int'($urandom_range(0, (1 << COORD_W) - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      if (gaps) repeat ($urandom_range(0, 6)) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, first, pulses;
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_x        = '0;
    bus.in_y        = '0;
    bus.in_relative = 1'b0;
    bus.in_elbow    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready",  int'(bus.in_ready), 1);
    check_eq("rst_count",     int'(bus.fifo_count), 0);
    check_eq("rst_busy",      int'(bus.busy), 0);
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_stage_en",  int'(bus.stage_en), 0);
    check_eq("rst_atan_en",   int'(bus.atan_en), 0);
    check_eq("rst_err_code",  int'(bus.err_code), 0);
    check_eq("rst_th1",       int'(bus.th1), 0);
    reset = 1'b1;

    rdy_mode = 1;
    fast     = 1;
    run_directed('h0100, 'h0200, 0, 0, 100, 500, 300, 'h100, 'h200, 400, 300);
    run_directed('h2005, 'h0005, 1, 1, -50, 4000, 200, -5, 5, 3950, -200);
    run_directed('h0003, 'h3fff, 1, 1, 1, 4095, 0, 3, -8191, -4096, 0);

    // Backpressure: consumer stalled while five targets are offered.
    rdy_mode = 0;
    push_random(5, 0);
    check_eq("bp_count",    int'(bus.fifo_count), 4);
    check_eq("bp_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    bus.in_x     = COORD_W'(123);
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("bp_full_hold", int'(bus.fifo_count), 4);
    repeat (10) @(negedge clk);
    rdy_mode = 2;
    wait_drain();

    // Timeout in SIN, followed by a healthy job.
    rdy_mode = 1;
    fast     = 1;
    hang_id  = 2;
    hang_en  = 1;
    push_job('h0111, 'h0222, 0, 0, 0);
    push_job('h0333, 'h0044, 0, 1, 1);
    n = 0;
    while (!(bus.stage_en && bus.stage_id == 3'd2) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_reach_sin", int'(bus.stage_id), 2);
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.err_pulse) begin
        pulses++;
        if (first < 0) first = i;
        hang_en = 0;
        check_eq("to_err_code", int'(bus.err_code), 2);
        check_eq("to_th1_hold", int'(bus.th1), last_th1);
        check_eq("to_th2_hold", int'(bus.th2), last_th2);
      end
    end
    check_eq("to_pulse_time",  first, 8);
    check_eq("to_pulse_count", pulses, 1);
    hang_en = 0;
    wait_drain();
    check_eq("to_err_code_kept", int'(bus.err_code), 2);

    // Spurious done strobes with random engine latency and random consumer.
    spur     = 1;
    fast     = 0;
    rdy_mode = 2;
    push_random(10, 1);
    wait_drain();
    spur = 0;

    push_random(30, 1);
    wait_drain();

    // Reset in ATANXY with two targets still queued.
    rdy_mode = 1;
    fast     = 1;
    push_job('h0010, 'h0020, 0, 0, 0);
    push_job('h0030, 'h0040, 0, 1, 0);
    push_job('h0050, 'h0060, 1, 0, 0);
    n = 0;
    while (!(bus.atan_en && bus.atan_sel == 2'd1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("mr_reach_atanxy", int'(bus.atan_sel), 1);
    check_eq("mr_queued",       int'(bus.fifo_count), 2);
    #2 reset = 1'b0;
    #1;
    check_eq("mr_out_valid", int'(bus.out_valid), 0);
    check_eq("mr_count",     int'(bus.fifo_count), 0);
    check_eq("mr_busy",      int'(bus.busy), 0);
    check_eq("mr_atan_en",   int'(bus.atan_en), 0);
    check_eq("mr_in_ready",  int'(bus.in_ready), 1);
    check_eq("mr_th1",       int'(bus.th1), 0);
    check_eq("mr_conv_x",    int'(bus.conv_x), 0);
    check_eq("mr_err_code",  int'(bus.err_code), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("mr_idle_after", int'(bus.busy), 0);
    check_eq("mr_count_after", int'(bus.fifo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
